cwt_result_streamer: RTL
========================

# cwt_result_streamer

Downstream stage of the CWT control unit. Once all J1 scale rows of N IFFT samples are in the result BRAM, this block reads them back in address order and emits them as an AXI4-Stream frame toward the DMA/data-loader. It absorbs the 1-cycle BRAM read latency and downstream backpressure with a 2-entry buffer, and sustains 1 beat/cycle. Its busy_o drives the control unit's dl_busy_i.

## Interface
- N, 1024: samples per scale row; power of two.
- J1, 64: scale rows per frame; power of two.
- DW, 32: sample width (BRAM read data, tdata).
- AW, $clog2(N*J1): BRAM address width; derived, not overridable.

- clk  in  1  clock.
- rstn  in  1  reset, asynchronous, active-low.
- start_i  in  1  1-cycle pulse: BRAM holds a complete frame.
- bram_en_o  out  1  BRAM read enable.
- bram_addr_o  out  AW  BRAM read address.
- bram_rdata_i  in  DW  BRAM data, valid the cycle after bram_en_o.
- m_axis_tdata  out  DW  sample.
- m_axis_tvalid  out  1  beat valid.
- m_axis_tready  in  1  sink ready.
- m_axis_tlast  out  1  last sample of a scale row, i.e. every N-th beat.
- m_axis_tuser  out  1  first beat of the frame (SOF).
- busy_o  out  1  frame in progress.
- done_o  out  1  1-cycle pulse after the final beat is accepted.

## Operation
- State machine:
  - S_IDLE → S_STREAM on start_i.
  - S_STREAM → S_DRAIN after the read of address N*J1-1 is issued.
  - S_DRAIN → S_DONE when beat N*J1-1 is accepted (tvalid&tready).
  - S_DONE → S_IDLE unconditionally after 1 cycle.
- Read side (S_STREAM only):
  - bram_en_o=1 and the address counter increments when credit is available.
  - Credit: occupancy + in-flight − (pop this cycle) < 2. In-flight is 1 for the cycle after a read.
- Arriving bram_rdata_i is written into the 2-entry buffer at the end of its valid cycle.
- Output side:
  - tvalid = buffer not empty; tdata = buffer head.
  - Pop on tvalid&tready.
  - tdata, tvalid and tlast stay stable while tvalid&~tready (AXI rule).
- Beat counter (AW+1 bits) counts accepted beats.
  - tlast = (beat_cnt[log2 N-1:0] == N-1).
  - tuser = (beat_cnt == 0).
- busy_o = state != S_IDLE. done_o = (state == S_DONE).
- start_i outside S_IDLE is ignored; no queuing.
- Buffer overflow is impossible by the credit rule. A write to a full buffer is an assertion failure.

## Timing
- Reset values: state S_IDLE; counters 0; buffer empty; all outputs 0, including bram_addr_o.
- Latency, start_i in cycle 0:
  - cycle 1: bram_en_o=1, addr 0.
  - cycle 2: data for addr 0 arrives.
  - cycle 3: tvalid=1, tuser=1.
- Throughput: tready held high gives 1 beat/cycle, no bubbles. Frame length N*J1 beats.
- With tready held high: last beat accepted in cycle N*J1+2; done_o in cycle N*J1+3; busy_o low from cycle N*J1+4.
- Backpressure: tready low stalls reads within 1 cycle. Buffer holds ≤2 samples. No data is lost or duplicated.
- Simultaneous push and pop on a full buffer is legal: occupancy is unchanged.
- Address counter stops at N*J1-1 and never wraps within a frame. It clears to 0 in S_IDLE.
- rstn asserted mid-frame: immediate return to reset values. The partial frame is abandoned without tlast; the next start_i begins a fresh frame at address 0.

## Structure
- Shared package cwt_pkg:
  - state enum (S_IDLE, S_STREAM, S_DRAIN, S_DONE);
  - localparam helpers for AW and log2 N;
  - DW default, shared with the control unit and IFFT wrapper.
- Sub-module cwt_skid_fifo: 2-entry register FIFO.
  - Parameter: DW.
  - Ports: push, pop, din, dout, empty, count.
- Top module holds the FSM, the read credit and the counters.

## Test plan
- Small config N=8, J1=4, BRAM preloaded with data=address, tready=1, start_i in cycle 0:
  - first tvalid in cycle 3 with tdata=0 and tuser=1;
  - 32 contiguous beats, tdata 0..31;
  - tlast on beats 7, 15, 23, 31;
  - done_o in cycle 35.
- Random tready (50%):
  - all 32 values arrive in order, no duplicates;
  - tdata/tlast stable while stalled;
  - buffer count never exceeds 2.
- tready=0 from cycle 2 for 10 cycles, then 1:
  - bram_en_o stops after 2 outstanding reads;
  - stream resumes with tdata=0, then 1, 2, … without a gap.
- start_i pulsed again at beat 5:
  - ignored; a single frame of 32 beats;
  - busy_o stays 1 until S_DONE ends.
- rstn low at beat 12, then high, then start_i:
  - all outputs 0 during reset;
  - new frame starts with tdata=0 and tuser=1.
- Default N=1024, J1=64, tready=1: 65536 beats, last tdata=65535 with tlast=1, one done_o pulse.

Source files
------------

// File: rtl/cwt_pkg.sv
// Shared definitions for the CWT control unit, IFFT wrapper and result
// streamer.
//   CWT_DW        default sample width on the BRAM and AXI4-Stream paths
//   cwt_state_e   result streamer FSM states
//   cwt_aw()      BRAM address width for an N x J1 frame
//   cwt_log2()    log2 of a power-of-two size (row-index width)
package cwt_pkg;

  localparam int CWT_DW = 32;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DRAIN  = 2'd2,
    S_DONE   = 2'd3
  } cwt_state_e;

  function automatic int cwt_aw(input int n, input int j1);
    return $clog2(n * j1);
  endfunction

  function automatic int cwt_log2(input int v);
    return $clog2(v);
  endfunction

endpackage

// File: rtl/cwt_skid_fifo.sv
// Two-entry register FIFO that absorbs the BRAM read latency and downstream
// backpressure in front of the AXI4-Stream output.
//   clk, rstn  clock, asynchronous active-low reset
//   push, din  write din at the end of this cycle
//   pop        drop the head at the end of this cycle (only when not empty)
//   dout       current head entry
//   empty      no entry held
//   count      number of entries held (0..2)
module cwt_skid_fifo
  import cwt_pkg::*;
#(
  parameter int DW = CWT_DW
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          empty,
  output logic [1:0]    count
);

  logic [DW-1:0] mem_q [2];
  logic [DW-1:0] mem_d [2];
  logic          wr_ptr_q, wr_ptr_d;
  logic          rd_ptr_q, rd_ptr_d;
  logic [1:0]    count_q,  count_d;

  always_comb begin
    // NOTE: every signal driven here gets a default first so that no path
    // leaves it unassigned and a latch is never inferred.
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + 2'(push) - 2'(pop);
    if (push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      // NOTE: the storage is only two words and feeds tdata directly, so it is
      // reset to keep the output at zero while the block is in reset.
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign dout  = mem_q[rd_ptr_q];
  assign empty = (count_q == 2'd0);
  assign count = count_q;

  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  a_no_overflow : assert property (@(posedge clk) disable iff (!rstn)
    !(push && !pop && (count_q == 2'd2)));

endmodule

// File: rtl/cwt_result_streamer.sv
// Reads a complete N x J1 result frame out of the result BRAM in address
// order and emits it as one AXI4-Stream frame at up to 1 beat per cycle.
//   clk, rstn       clock, asynchronous active-low reset
//   start_i         1-cycle pulse: BRAM holds a complete frame
//   bram_en_o       BRAM read enable
//   bram_addr_o     BRAM read address
//   bram_rdata_i    BRAM read data, valid the cycle after bram_en_o
//   m_axis_*        AXI4-Stream master (tlast every N beats, tuser on beat 0)
//   busy_o          frame in progress (drives the control unit's dl_busy_i)
//   done_o          1-cycle pulse after the final beat is accepted
module cwt_result_streamer
  import cwt_pkg::*;
#(
  parameter  int N  = 1024,
  parameter  int J1 = 64,
  parameter  int DW = CWT_DW,
  localparam int AW = cwt_aw(N, J1)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          start_i,
  output logic          bram_en_o,
  output logic [AW-1:0] bram_addr_o,
  input  logic [DW-1:0] bram_rdata_i,
  output logic [DW-1:0] m_axis_tdata,
  output logic          m_axis_tvalid,
  input  logic          m_axis_tready,
  output logic          m_axis_tlast,
  output logic          m_axis_tuser,
  output logic          busy_o,
  output logic          done_o
);

  localparam int            LOGN      = cwt_log2(N);
  localparam logic [AW-1:0] LAST_ADDR = AW'(N * J1 - 1);
  localparam logic [AW:0]   LAST_BEAT = (AW + 1)'(N * J1 - 1);

  cwt_state_e    state_q, state_d;
  logic [AW-1:0] addr_q,  addr_d;
  logic [AW:0]   beat_q,  beat_d;
  logic          inflight_q, inflight_d;

  logic          fifo_empty;
  logic [1:0]    fifo_count;
  logic          pop;
  logic          rd_ok;
  logic [2:0]    credit_used;

  cwt_skid_fifo #(.DW(DW)) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (inflight_q),
    .pop   (pop),
    .din   (bram_rdata_i),
    .dout  (m_axis_tdata),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign m_axis_tvalid = ~fifo_empty;
  assign pop           = m_axis_tvalid & m_axis_tready;

  // Slots already claimed: held entries plus the read whose data lands this
  // cycle, less the entry leaving this cycle. A new read needs one free slot.
  assign credit_used = 3'(fifo_count) + 3'(inflight_q) - 3'(pop);
  assign rd_ok       = (credit_used < 3'd2);
  assign bram_en_o   = (state_q == S_STREAM) && rd_ok;
  assign inflight_d  = bram_en_o;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    beat_d  = pop ? beat_q + 1'b1 : beat_q;
    case (state_q)
      S_IDLE: begin
        addr_d = '0;
        beat_d = '0;
        if (start_i) state_d = S_STREAM;
      end
      S_STREAM: begin
        if (bram_en_o) begin
          // Hold on the final address; the frame never wraps.
          if (addr_q == LAST_ADDR) state_d = S_DRAIN;
          else                     addr_d  = addr_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (pop && (beat_q == LAST_BEAT)) state_d = S_DONE;
      end
      S_DONE: begin
        addr_d  = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      beat_q     <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      beat_q     <= beat_d;
      inflight_q <= inflight_d;
    end
  end

  assign bram_addr_o  = addr_q;
  // Flags are qualified by tvalid so they read 0 whenever no beat is offered.
  assign m_axis_tlast = m_axis_tvalid && (beat_q[LOGN-1:0] == LOGN'(N - 1));
  assign m_axis_tuser = m_axis_tvalid && (beat_q == '0);
  assign busy_o       = (state_q != S_IDLE);
  assign done_o       = (state_q == S_DONE);

endmodule
